// File: rtl/router_input_deser.sv
// router_input_deser
//   Per-lane serial input deserializer. Parses a serial packet into a
//   destination address (LSB first), a fixed pad phase and payload bytes
//   (LSB first). Each completed byte is presented on a one-entry
//   valid/ready output register. The serial side is never stalled: a byte
//   that completes while the register is full and not being popped is
//   dropped and flagged.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   din        serial data bit
//   frame_n    active-low frame envelope
//   valid_n    active-low data-valid qualifier
//   out_valid  output register holds a byte
//   out_ready  consumer accepts the byte this cycle
//   out_data   payload byte
//   out_addr   destination of the packet the byte belongs to
//   out_sop    byte is the first loaded byte of its packet
//   out_eop    byte is the last byte of its packet
//   frame_err  one-cycle pulse on a framing violation
//   ovf_err    one-cycle pulse when a completed byte is dropped
//   busy       high whenever the parser is not idle
module router_input_deser #(
    parameter int ADDR_W     = 1,
    parameter int PAD_CYCLES = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_sop,
    output logic              out_eop,
    output logic              frame_err,
    output logic              ovf_err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    localparam int AC_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    logic [1:0]        r_state;
    logic [AC_W-1:0]   r_addr_cnt;
    logic [3:0]        r_pad_cnt;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pkt_addr;
    logic              r_sop_pending;

    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_sop;
    logic              r_out_eop;
    logic              r_frame_err;
    logic              r_ovf_err;

    logic [ADDR_W-1:0] w_addr_next;
    logic              w_complete;
    logic              w_load;
    logic [7:0]        w_byte;

    // Address register with the current din written at bit r_addr_cnt.
    always_comb begin
        w_addr_next = r_addr;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (r_addr_cnt == AC_W'(i)) begin
                w_addr_next[i] = din;
            end
        end
    end

    // The shift register holds bits 0..6; the 8th bit comes straight from din.
    assign w_byte     = {din, r_shift};
    assign w_complete = (r_state == ST_DATA) && !valid_n && (r_bit_cnt == 3'd7);
    assign w_load     = w_complete && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr_cnt    <= '0;
            r_pad_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_addr        <= '0;
            r_pkt_addr    <= '0;
            r_sop_pending <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_addr    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_ovf_err     <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_ovf_err   <= w_complete && !w_load;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_byte;
                r_out_addr  <= r_pkt_addr;
                r_out_sop   <= r_sop_pending;
                r_out_eop   <= frame_n;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_pad_cnt <= '0;
                    if (!frame_n) begin
                        r_addr <= ADDR_W'(din);
                        if (ADDR_W > 1) begin
                            r_addr_cnt <= AC_W'(1);
                            r_state    <= ST_ADDR;
                        end else if (PAD_CYCLES > 0) begin
                            r_state <= ST_PAD;
                        end else begin
                            r_pkt_addr    <= ADDR_W'(din);
                            r_sop_pending <= 1'b1;
                            r_state       <= ST_DATA;
                        end
                    end
                end
                ST_ADDR: begin
                    if (frame_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_addr     <= w_addr_next;
                        r_addr_cnt <= r_addr_cnt + AC_W'(1);
                        if (r_addr_cnt == AC_W'(ADDR_W - 1)) begin
                            if (PAD_CYCLES > 0) begin
                                r_state <= ST_PAD;
                            end else begin
                                r_pkt_addr    <= w_addr_next;
                                r_sop_pending <= 1'b1;
                                r_state       <= ST_DATA;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (frame_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (r_pad_cnt == 4'(PAD_CYCLES - 1)) begin
                        r_pkt_addr    <= r_addr;
                        r_sop_pending <= 1'b1;
                        r_state       <= ST_DATA;
                    end else begin
                        r_pad_cnt <= r_pad_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (!valid_n) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            // sop survives a dropped byte so the next loaded byte carries it
                            if (w_load) begin
                                r_sop_pending <= 1'b0;
                            end
                            if (frame_n) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_shift   <= {din, r_shift[6:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (frame_n) begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end
                    end else if (frame_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign frame_err = r_frame_err;
    assign ovf_err   = r_ovf_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_router_input_deser.sv
// tb_router_input_deser
//   Directed bench for router_input_deser with ADDR_W=1, PAD_CYCLES=5.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   the same point, so each check reflects the edge that just sampled the
//   previously applied inputs.
module tb_router_input_deser;

    localparam int ADDR_W = 1;
    localparam int PAD    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              din;
    logic              frame_n;
    logic              valid_n;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_sop;
    logic              out_eop;
    logic              frame_err;
    logic              ovf_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    router_input_deser #(
        .ADDR_W(ADDR_W),
        .PAD_CYCLES(PAD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .frame_n(frame_n),
        .valid_n(valid_n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .frame_err(frame_err),
        .ovf_err(ovf_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        cyc();
    endtask

    task automatic start_pkt(input logic a);
        send_bit(1'b0, 1'b1, a);
        for (int i = 0; i < PAD; i++) send_bit(1'b0, 1'b1, 1'b0);
    endtask

    // Sends one byte LSB first; frame_n goes high on bit 7 when last is set.
    // With gaps set, idle bit cycles carrying random din precede bits 2 and 5.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i == 2 || i == 5)) send_bit(1'b0, 1'b1, 1'($urandom_range(1)));
            send_bit((last && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
        end
    endtask

    task automatic idle_cycle();
        send_bit(1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] d, input logic a,
                            input logic s, input logic e);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".addr"},  32'(out_addr),  32'(a));
        chk({tag, ".sop"},   32'(out_sop),   32'(s));
        chk({tag, ".eop"},   32'(out_eop),   32'(e));
    endtask

    initial begin
        reset     = 1'b1;
        din       = 1'b0;
        frame_n   = 1'b1;
        valid_n   = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data",  32'(out_data),  32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        chk("rst.ferr",  32'(frame_err), 32'd0);
        chk("rst.oerr",  32'(ovf_err),   32'd0);
        reset = 1'b0;
        idle_cycle();

        // Single byte 0xA5 to address 1
        send_bit(1'b0, 1'b1, 1'b1);
        chk("t1.busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < PAD; i++) send_bit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'(8'hA5 >> i));
        chk("t1.not_yet", 32'(out_valid), 32'd0);
        chk("t1.busy_mid", 32'(busy), 32'd1);
        send_bit(1'b1, 1'b0, 1'b1);
        chk_byte("t1", 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("t1.busy_fall", 32'(busy), 32'd0);
        chk("t1.ferr", 32'(frame_err), 32'd0);
        chk("t1.oerr", 32'(ovf_err), 32'd0);
        idle_cycle();
        chk("t1.popped", 32'(out_valid), 32'd0);

        // Three bytes to address 0 with idle bit cycles
        start_pkt(1'b0);
        send_byte(8'h01, 1'b0, 1'b1);
        chk_byte("t2.b0", 8'h01, 1'b0, 1'b1, 1'b0);
        send_byte(8'h80, 1'b0, 1'b1);
        chk_byte("t2.b1", 8'h80, 1'b0, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1);
        chk_byte("t2.b2", 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("t2.ferr", 32'(frame_err), 32'd0);
        idle_cycle();

        // Framing error after 3 data bits
        start_pkt(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("t3.ferr", 32'(frame_err), 32'd1);
        chk("t3.valid", 32'(out_valid), 32'd0);
        chk("t3.busy", 32'(busy), 32'd0);
        idle_cycle();
        chk("t3.ferr_1cyc", 32'(frame_err), 32'd0);

        // Framing error during pad cycle 2
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("t3p.ferr", 32'(frame_err), 32'd1);
        chk("t3p.valid", 32'(out_valid), 32'd0);
        chk("t3p.busy", 32'(busy), 32'd0);
        idle_cycle();
        chk("t3p.ferr_1cyc", 32'(frame_err), 32'd0);

        // Overrun: consumer never ready
        out_ready = 1'b0;
        start_pkt(1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        chk_byte("t4.b0", 8'h11, 1'b0, 1'b1, 1'b0);
        chk("t4.no_ovf", 32'(ovf_err), 32'd0);
        send_byte(8'h22, 1'b1, 1'b0);
        chk("t4.ovf", 32'(ovf_err), 32'd1);
        chk_byte("t4.held", 8'h11, 1'b0, 1'b1, 1'b0);
        chk("t4.busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        idle_cycle();
        chk("t4.ovf_1cyc", 32'(ovf_err), 32'd0);
        chk("t4.popped", 32'(out_valid), 32'd0);

        // Back-to-back packets
        start_pkt(1'b1);
        send_byte(8'h3C, 1'b1, 1'b0);
        chk_byte("t5.p0", 8'h3C, 1'b1, 1'b1, 1'b1);
        start_pkt(1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
        chk_byte("t5.p1", 8'hC3, 1'b0, 1'b1, 1'b1);
        chk("t5.ferr", 32'(frame_err), 32'd0);

        // Reset mid-packet while a byte is held
        out_ready = 1'b0;
        start_pkt(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b1);
        chk("t6.held", 32'(out_valid), 32'd1);
        reset = 1'b1;
        cyc();
        chk("t6.valid", 32'(out_valid), 32'd0);
        chk("t6.data",  32'(out_data),  32'd0);
        chk("t6.addr",  32'(out_addr),  32'd0);
        chk("t6.sop",   32'(out_sop),   32'd0);
        chk("t6.eop",   32'(out_eop),   32'd0);
        chk("t6.ferr",  32'(frame_err), 32'd0);
        chk("t6.busy",  32'(busy),      32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        frame_n   = 1'b1;
        valid_n   = 1'b1;
        cyc();
        chk("t6.ferr_after", 32'(frame_err), 32'd0);
        start_pkt(1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        chk_byte("t6.clean", 8'h5A, 1'b0, 1'b1, 1'b1);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
